// File: rtl/ehl_clock_div_pkg.sv
// ehl_clock_div_pkg: shared constants, cell modes and a clog2 helper for the clock divider
package ehl_clock_div_pkg;
  localparam int TECH_GENERIC = 0;
  localparam int TECH_LIB1 = 1;
  localparam int DIV_MIN = 1;
  localparam int DIV_MAX = 256;
  localparam int SYNC_MAX = 3;
  typedef enum logic {MODE_ODD, MODE_BYPASS} cell_mode_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/ehl_clock_div_cell.sv
// ehl_clock_div_cell: falling-edge hold element plus clock OR/AND combine, per technology
module ehl_clock_div_cell
  import ehl_clock_div_pkg::*;
#(
  parameter int TECHNOLOGY = TECH_GENERIC,
  parameter cell_mode_e MODE = MODE_ODD
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic d,
  output logic clk_out
);
  logic hold;
  if (MODE == MODE_ODD) begin : g_neg
    always_ff @(negedge clk_in or negedge reset_n)
      if (!reset_n) hold <= 1'b0;
      else hold <= d;
  end else begin : g_lat
    // enable only moves while clk_in is low, so the AND gate cannot chop a pulse
    always_latch
      if (!reset_n) hold <= 1'b0;
      else if (!clk_in) hold <= d;
  end
  if (TECHNOLOGY == TECH_LIB1) begin : g_lib
    assign clk_out = (MODE == MODE_ODD) ? (d ? 1'b1 : hold) : (clk_in ? hold : 1'b0);
  end else begin : g_gen
    assign clk_out = (MODE == MODE_ODD) ? (d | hold) : (clk_in & hold);
  end
endmodule

// File: rtl/ehl_clock_div.sv
// ehl_clock_div: integer clock divider with 50% duty for even and odd ratios
module ehl_clock_div
  import ehl_clock_div_pkg::*;
#(
  parameter int TECHNOLOGY = TECH_GENERIC,
  parameter int DIV = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset_n,
  output logic clk_out
);
  localparam int TECH = (TECHNOLOGY == TECH_LIB1) ? TECH_LIB1 : TECH_GENERIC;
  logic rel;
  if (DIV < DIV_MIN || DIV > DIV_MAX) begin : g_bad_div
    $fatal(1, "ehl_clock_div: DIV=%0d outside %0d..%0d", DIV, DIV_MIN, DIV_MAX);
  end
  if (SYNC_STAGES < 0 || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $fatal(1, "ehl_clock_div: SYNC_STAGES=%0d outside 0..%0d", SYNC_STAGES, SYNC_MAX);
  end
  if (SYNC_STAGES == 0) begin : g_nosync
    assign rel = reset_n;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync;
    always_ff @(posedge clk_in or negedge reset_n)
      if (!reset_n) sync <= '0;
      else sync <= (sync << 1) | SYNC_STAGES'(1);
    assign rel = sync[SYNC_STAGES-1];
  end
  if (DIV == 1) begin : g_bypass
    ehl_clock_div_cell #(.TECHNOLOGY(TECH), .MODE(MODE_BYPASS)) u_cell (
      .clk_in(clk_in),
      .reset_n(reset_n),
      .d(rel),
      .clk_out(clk_out)
    );
  end else begin : g_div
    localparam int CW = clog2(DIV);
    logic [CW-1:0] cnt, cnt_nx;
    logic started, ph_p;
    // first active edge loads 0 so the output rises immediately with a full high phase
    assign cnt_nx = (!started || cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
    always_ff @(posedge clk_in or negedge reset_n)
      if (!reset_n) begin
        cnt <= '0;
        started <= 1'b0;
        ph_p <= 1'b0;
      end else if (rel) begin
        cnt <= cnt_nx;
        started <= 1'b1;
        ph_p <= cnt_nx < CW'(DIV / 2);
      end
    if (DIV % 2 == 0) begin : g_even
      assign clk_out = ph_p;
    end else begin : g_odd
      ehl_clock_div_cell #(.TECHNOLOGY(TECH), .MODE(MODE_ODD)) u_cell (
        .clk_in(clk_in),
        .reset_n(reset_n),
        .d(ph_p),
        .clk_out(clk_out)
      );
    end
  end
endmodule

// File: tb/tb_ehl_clock_div.sv
// tb_ehl_clock_div: randomized reset/release stimulus across DIV/SYNC/TECH, checked against a time-domain model
module tb_ehl_clock_div;
  localparam int NC = 14;
  localparam int DIVS [NC] = '{1, 1, 2, 2, 3, 3, 4, 5, 5, 8, 8, 3, 4, 7};
  localparam int SYNS [NC] = '{0, 2, 0, 2, 0, 2, 2, 0, 2, 0, 2, 1, 3, 3};
  localparam int I_D5S2 = 8;
  logic clk_in = 1'b0;
  logic reset_n = 1'b0;
  logic [NC-1:0][2:0] outs;
  int vectors = 0;
  int miscompares = 0;
  bit released = 1'b0;
  longint t_r = 0;
  always #10 clk_in = ~clk_in;
  for (genvar c = 0; c < NC; c++) begin : g_c
    for (genvar k = 0; k < 3; k++) begin : g_t
      ehl_clock_div #(.TECHNOLOGY(k), .DIV(DIVS[c]), .SYNC_STAGES(SYNS[c])) u_dut (
        .clk_in(clk_in),
        .reset_n(reset_n),
        .clk_out(outs[c][k])
      );
    end
  end
  // output is high for the first DIV*10 time units of every DIV*20 window starting at edge R+SYNC_STAGES
  function automatic logic model(int c, longint t);
    longint st, per;
    st = t_r + longint'(SYNS[c] * 20);
    per = longint'(DIVS[c] * 20);
    if (!reset_n || !released || t < st) return 1'b0;
    return ((t - st) % per) < (per / 2);
  endfunction
  task automatic test_reset();
    repeat (13) begin
      @(clk_in);
      #1;
      for (int c = 0; c < NC; c++)
        for (int k = 0; k < 3; k++) begin
          vectors++;
          if (outs[c][k] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold div%0d sync%0d tech%0d t=%0t got %b want 0", DIVS[c], SYNS[c], k, $time, outs[c][k]);
          end
        end
    end
  endtask
  task automatic test_release(int n);
    logic e;
    #9;
    reset_n = 1'b1;
    repeat (n) begin
      @(clk_in);
      if (clk_in && reset_n && !released) begin released = 1'b1; t_r = longint'($time); end
      #1;
      for (int c = 0; c < NC; c++)
        for (int k = 0; k < 3; k++) begin
          e = model(c, longint'($time));
          vectors++;
          if (outs[c][k] !== e) begin
            miscompares++;
            $display("FAIL release div%0d sync%0d tech%0d t=%0t got %b want %b", DIVS[c], SYNS[c], k, $time, outs[c][k], e);
          end
        end
    end
  endtask
  task automatic test_mid_reset();
    logic e;
    bit found;
    longint ph;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(clk_in);
      if (clk_in && reset_n && !released) begin released = 1'b1; t_r = longint'($time); end
      #1;
      for (int c = 0; c < NC; c++)
        for (int k = 0; k < 3; k++) begin
          e = model(c, longint'($time));
          vectors++;
          if (outs[c][k] !== e) begin
            miscompares++;
            $display("FAIL pre_reset div%0d sync%0d tech%0d t=%0t got %b want %b", DIVS[c], SYNS[c], k, $time, outs[c][k], e);
          end
        end
      ph = longint'($time) - 1 - (t_r + longint'(SYNS[I_D5S2] * 20));
      found = released && clk_in && ph >= 0 && (ph % 100) == 0;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL mid_reset_wait got no period start want one within 200 edges");
    end
    #4;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (outs[I_D5S2][k] !== 1'b1) begin
        miscompares++;
        $display("FAIL mid_high div5 tech%0d t=%0t got %b want 1", k, $time, outs[I_D5S2][k]);
      end
    end
    reset_n = 1'b0;
    released = 1'b0;
    #1;
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (outs[c][k] !== 1'b0) begin
          miscompares++;
          $display("FAIL async_drop div%0d sync%0d tech%0d t=%0t got %b want 0", DIVS[c], SYNS[c], k, $time, outs[c][k]);
        end
      end
    #25;
    reset_n = 1'b1;
    repeat (200) begin
      @(clk_in);
      if (clk_in && reset_n && !released) begin released = 1'b1; t_r = longint'($time); end
      #1;
      for (int c = 0; c < NC; c++)
        for (int k = 0; k < 3; k++) begin
          e = model(c, longint'($time));
          vectors++;
          if (outs[c][k] !== e) begin
            miscompares++;
            $display("FAIL restart div%0d sync%0d tech%0d t=%0t got %b want %b", DIVS[c], SYNS[c], k, $time, outs[c][k], e);
          end
        end
    end
  endtask
  task automatic test_random(int iters);
    logic e;
    int d;
    repeat (iters) begin
      d = int'($urandom_range(1, 7));
      #d;
      reset_n = 1'b0;
      released = 1'b0;
      #1;
      for (int c = 0; c < NC; c++)
        for (int k = 0; k < 3; k++) begin
          vectors++;
          if (outs[c][k] !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_assert div%0d sync%0d tech%0d t=%0t got %b want 0", DIVS[c], SYNS[c], k, $time, outs[c][k]);
          end
        end
      d = int'($urandom_range(1, 80));
      if (((longint'($time) + longint'(d)) % 10) == 0) d++;
      #d;
      reset_n = 1'b1;
      repeat (int'($urandom_range(20, 200))) begin
        @(clk_in);
        if (clk_in && reset_n && !released) begin released = 1'b1; t_r = longint'($time); end
        #1;
        for (int c = 0; c < NC; c++)
          for (int k = 0; k < 3; k++) begin
            e = model(c, longint'($time));
            vectors++;
            if (outs[c][k] !== e) begin
              miscompares++;
              $display("FAIL random div%0d sync%0d tech%0d t=%0t got %b want %b", DIVS[c], SYNS[c], k, $time, outs[c][k], e);
            end
          end
      end
    end
  endtask
  initial begin
    test_reset();
    test_release(240);
    test_mid_reset();
    test_random(8);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ehl_clock_div.md
Name: ehl_clock_div

Overview:
- Integer clock divider; produces clk_out at f(clk_in)/DIV with 50% duty for even and odd ratios.
- Odd ratios use both clk_in edges.
- Sits at clock-generation level, feeding downstream clock domains.
- TECHNOLOGY selects generic RTL or technology-mapped cells. Output is edge-for-edge identical for every TECHNOLOGY value.

Parameters:
- TECHNOLOGY, 0: implementation select.
  - 0 = generic RTL.
  - 1 = mapped library cells (clock mux/AND, flops).
  - Unsupported values fall back to generic.
- DIV, 3: division ratio, integer 1..256.
  - DIV=1 is bypass.
  - DIV<1 is a fatal elaboration error.
- SYNC_STAGES, 2: reset-deassertion synchronizer depth, 0..3. 0 = reset_n used directly.

Ports:
- clk_in  input  1  source clock; single clock domain.
- reset_n  input  1  asynchronous active-low reset. Assertion is immediate; deassertion is synchronized to rising clk_in through SYNC_STAGES flops.
- clk_out  output  1  divided clock.

Behaviour:
- Reset (reset_n=0):
  - clk_out=0 asynchronously.
  - Counter=0; all phase flops=0; synchronizer flops=0.
  - Holds for any clk_in activity.
- Edge numbering: let R be the first rising clk_in edge at which reset_n is sampled 1, numbered 0. Internal reset releases at edge R+SYNC_STAGES-1 (immediately for SYNC_STAGES=0).
- Counter:
  - cnt, width clog2(DIV), rising-edge, counts 0..DIV-1 and wraps to 0.
  - Starts at the first rising edge after internal release, which is edge R+SYNC_STAGES.
- Phase flop ph_p (rising-edge): value is 1 while cnt is in 0..floor(DIV/2)-1 after the update, else 0.
- First output edge: clk_out rises at rising edge R+SYNC_STAGES (clk-to-q).
- Even DIV: clk_out = ph_p. High DIV/2 input periods, low DIV/2.
- Odd DIV>=3:
  - ph_n is ph_p resampled on the falling clk_in edge.
  - clk_out = ph_p OR ph_n. High (DIV/2) periods = floor(DIV/2)+0.5; falls on a falling clk_in edge.
  - For DIV=3: high 1.5 periods, low 1.5 periods.
- DIV=1: clk_out = clk_in AND internal-reset-released, through a glitch-free gate (gate enable latched while clk_in low).
- Steady state:
  - clk_out period = DIV clk_in periods exactly.
  - Output transitions only on clk_in edges; no glitches, no runt pulses at reset release.
- Reset mid-operation: clk_out drops to 0 immediately, even mid-high-phase. Restart follows the rule above.
- Equivalence: for every TECHNOLOGY, clk_out is bit-identical when sampled 1 time unit after every clk_in edge, both in reset and out of reset.
- Output combine (OR/mux/gate) goes through the technology cell wrapper only. Generic path uses plain logic.

Decomposition:
- Package ehl_clock_div_pkg holds:
  - TECH_GENERIC=0 and TECH_LIB1=1 constants.
  - A clog2 function.
  - DIV range limits.
- Sub-module ehl_clock_div_cell: technology wrapper for the clock OR/AND gate and the negedge flop. Selects a generate branch by TECHNOLOGY.
- Counter and synchronizer stay in the top module.

Test Plan:
- Reset hold: clk_in period 20, reset_n=0 for 140 -> clk_out=0 throughout; both TECHNOLOGY 0 and 1 agree at t=30.
- DIV=3, SYNC_STAGES=2, release at t=140:
  - clk_out first rises at rising edge R+2.
  - Then high 30 time units, low 30, period 60.
  - 40 cycles with zero mismatches vs TECHNOLOGY=0.
- DIV=4: high 40, low 40 after first rise; each transition aligned to a rising clk_in edge.
- DIV=1: clk_out equals clk_in from edge R+SYNC_STAGES; first pulse is full-width.
- Reset mid-high-phase (DIV=5): assert reset_n=0 while clk_out=1 -> clk_out=0 within the same time step; restart timing is identical to the first release.
- Cross-check loop: TECHNOLOGY 0 vs 1, DIV in {2,3,5,8}, SYNC_STAGES in {0,2} -> compare 1 time unit after every clk_in edge; error count must be 0.
